// File: rtl/piccolo_sched.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : piccolo_sched
// Purpose  : Round-robin two-requester sequencer for a shared iterative Piccolo
//            round core; returns ciphertext with requester ID.
// Revision : 1.0
//------------------------------------------------------------------------------
module piccolo_sched #(
    parameter int ROUNDS80  = 25,
    parameter int ROUNDS128 = 31
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [1:0]     req_version,
    input  logic [0:63]    req_text0,
    input  logic [0:63]    req_text1,
    input  logic [0:127]   req_key0,
    input  logic [0:127]   req_key1,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [0:63]    rsp_text,
    output logic           busy,
    output logic           core_start,
    output logic           core_step,
    output logic [4:0]     core_round,
    output logic           core_version,
    output logic [0:63]    core_text,
    output logic [0:127]   core_key,
    input  logic [0:63]    core_result
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_RUN  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam logic [4:0] c_N80  = 5'(ROUNDS80);
    localparam logic [4:0] c_N128 = 5'(ROUNDS128);

    logic [1:0]   r_state;
    logic [1:0]   w_next_state;
    logic         r_last_grant;
    logic         r_cooldown;
    logic         r_id;
    logic         r_version;
    logic [0:63]  r_text;
    logic [0:127] r_key;
    logic [4:0]   r_round;
    logic         r_first_done;
    logic [0:63]  r_rsp_text;

    logic         w_winner;
    logic         w_accept;
    logic [4:0]   w_rounds;
    logic         w_last_round;

    // A tie goes to the requester that did not win last time.
    always_comb begin
        w_winner  = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
        req_ready = 2'b00;
        if ((r_state == c_ST_IDLE) && !r_cooldown && (req_valid != 2'b00)) begin
            req_ready = w_winner ? 2'b10 : 2'b01;
        end
        w_accept     = (req_ready != 2'b00);
        w_rounds     = r_version ? c_N128 : c_N80;
        w_last_round = (r_round == w_rounds);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept)     w_next_state = c_ST_LOAD;
            c_ST_LOAD:                   w_next_state = c_ST_RUN;
            c_ST_RUN:  if (w_last_round) w_next_state = c_ST_DONE;
            c_ST_DONE: if (rsp_ready)    w_next_state = c_ST_IDLE;
            default:                     w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (r_state != c_ST_IDLE);
        core_start = (r_state == c_ST_LOAD);
        core_step  = (r_state == c_ST_RUN);
        core_round = core_step ? r_round : 5'd0;
        rsp_valid  = (r_state == c_ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_cooldown   <= 1'b0;
            r_id         <= 1'b0;
            r_version    <= 1'b0;
            r_text       <= '0;
            r_key        <= '0;
            r_round      <= 5'd0;
            r_first_done <= 1'b0;
            r_rsp_text   <= '0;
        end else begin
            r_first_done <= (r_state == c_ST_RUN) && w_last_round;
            // Blocks acceptance for one IDLE cycle after a response retires.
            r_cooldown   <= (r_state == c_ST_DONE) && rsp_ready;
            if (w_accept) begin
                r_id         <= w_winner;
                r_last_grant <= w_winner;
                r_version    <= req_version[w_winner];
                r_text       <= w_winner ? req_text1 : req_text0;
                r_key        <= w_winner ? req_key1  : req_key0;
            end
            if (r_state == c_ST_LOAD) begin
                r_round <= 5'd1;
            end else if ((r_state == c_ST_RUN) && !w_last_round) begin
                r_round <= r_round + 5'd1;
            end
            if (r_first_done) begin
                r_rsp_text <= core_result;
            end
        end
    end

    // The core result becomes valid on DONE entry; pass it through for that
    // cycle and hold the captured copy afterwards.
    assign rsp_text     = r_first_done ? core_result : r_rsp_text;
    assign rsp_id       = r_id;
    assign core_version = r_version;
    assign core_text    = r_text;
    assign core_key     = r_key;

endmodule
`default_nettype wire

// File: tb/tb_piccolo_sched.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_piccolo_sched
// Purpose  : Scoreboard bench for piccolo_sched with a toy iterative core.
// Revision : 1.0
//------------------------------------------------------------------------------
module tb_piccolo_sched;

    logic         clk;
    logic         reset;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [1:0]   req_version;
    logic [63:0]  t0, t1;
    logic [127:0] k0, k1;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [63:0]  rsp_text;
    logic         busy, core_start, core_step, core_version;
    logic [4:0]   core_round;
    logic [63:0]  core_text, core_result;
    logic [127:0] core_key;

    logic v0, v1, ver0, ver1, rdy_dir, rdy_rand, rand_mode;
    assign req_valid   = {v1, v0};
    assign req_version = {ver1, ver0};
    assign rsp_ready   = rand_mode ? rdy_rand : rdy_dir;

    piccolo_sched #(.ROUNDS80(25), .ROUNDS128(31)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_version(req_version),
        .req_text0(t0), .req_text1(t1), .req_key0(k0), .req_key1(k1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_text(rsp_text), .busy(busy),
        .core_start(core_start), .core_step(core_step), .core_round(core_round),
        .core_version(core_version), .core_text(core_text), .core_key(core_key),
        .core_result(core_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Toy core: any wrong round count or round index changes the result.
    logic [63:0] st = '0;
    always @(posedge clk) begin
        if (core_start)
            st <= core_text ^ core_key[127:64] ^ {63'b0, core_version};
        else if (core_step)
            st <= {st[62:0], st[63]} ^ {59'b0, core_round} ^ (core_version ? 64'hA5 : 64'h0);
    end
    assign core_result = st;

    function automatic logic [63:0] model(input logic ver, input logic [63:0] t, input logic [127:0] k);
        logic [63:0] s;
        s = t ^ k[127:64] ^ {63'b0, ver};
        for (int r = 1; r <= (ver ? 31 : 25); r++)
            s = {s[62:0], s[63]} ^ 64'(r) ^ (ver ? 64'hA5 : 64'h0);
        return s;
    endfunction

    int t_run  = 0;
    int t_fail = 0;
    task automatic check(input logic ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        t_run++;
        if (!ok) begin
            t_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic        id;
        logic [63:0] text;
        int          n;
        int          acc;
    } entry_t;
    entry_t sb[$];
    int     acc_cyc[$];
    int     acc_ids[$];

    // Monitor: predicts grants, pushes expectations on accept, pops on response.
    logic tb_last = 1'b1;
    int   steps = 0, last_acc = -1000, last_n = 0;
    logic prev_rv = 1'b0, prev_rr = 1'b0, prev_id = 1'b0;
    logic [63:0] prev_txt = '0;
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            tb_last  = 1'b1;
            steps    = 0;
            prev_rv  = 1'b0;
            last_acc = -1000;
        end else begin
            check(req_ready != 2'b11, "ready_onehot", {62'b0, req_ready}, 64'h1);
            if (req_ready != 2'b00) begin
                if (req_valid == 2'b11)
                    check(req_ready == (tb_last ? 2'b01 : 2'b10), "tie_grant", {62'b0, req_ready}, {62'b0, (tb_last ? 2'b01 : 2'b10)});
                else
                    check(req_ready == req_valid, "single_grant", {62'b0, req_ready}, {62'b0, req_valid});
                for (int i = 0; i < 2; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        entry_t e;
                        e.id   = i[0];
                        e.text = model(req_version[i], i ? t1 : t0, i ? k1 : k0);
                        e.n    = req_version[i] ? 31 : 25;
                        e.acc  = cyc;
                        check(cyc - last_acc >= last_n + 4, "accept_spacing", 64'(cyc - last_acc), 64'(last_n + 4));
                        sb.push_back(e);
                        acc_cyc.push_back(cyc);
                        acc_ids.push_back(i);
                        tb_last  = i[0];
                        last_acc = cyc;
                        last_n   = e.n;
                    end
                end
            end
            if (core_start) begin
                check(!core_step && !rsp_valid, "start_exclusive", {62'b0, core_step, rsp_valid}, 64'h0);
                check(sb.size() == 1 && cyc == sb[0].acc + 1, "start_timing", 64'(sb.size()), 64'h1);
                steps = 0;
            end
            if (core_step) begin
                check(core_round == 5'(steps + 1), "round_index", {59'b0, core_round}, 64'(steps + 1));
                steps++;
            end
            if (rsp_valid) begin
                check(req_ready == 2'b00, "no_ready_in_done", {62'b0, req_ready}, 64'h0);
                if (!prev_rv) begin
                    if (sb.size() == 0) begin
                        check(1'b0, "unexpected_rsp", {63'b0, rsp_valid}, 64'h0);
                    end else begin
                        check(cyc - sb[0].acc == sb[0].n + 2, "rsp_latency", 64'(cyc - sb[0].acc), 64'(sb[0].n + 2));
                        check(steps == sb[0].n, "step_count", 64'(steps), 64'(sb[0].n));
                    end
                end
            end
            if (prev_rv && !prev_rr) begin
                check(rsp_valid, "rsp_held", {63'b0, rsp_valid}, 64'h1);
                check(rsp_text == prev_txt && rsp_id == prev_id, "rsp_stable", rsp_text, prev_txt);
            end
            if (rsp_valid && rsp_ready && sb.size() != 0) begin
                entry_t e;
                e = sb.pop_front();
                check(rsp_id == e.id, "rsp_id", {63'b0, rsp_id}, {63'b0, e.id});
                check(rsp_text == e.text, "rsp_text", rsp_text, e.text);
            end
            prev_rv  = rsp_valid;
            prev_rr  = rsp_ready;
            prev_id  = rsp_id;
            prev_txt = rsp_text;
        end
    end

    always @(posedge clk) #1 rdy_rand = ($urandom_range(0, 2) != 0);

    task automatic send(input int i, input logic ver, input logic [63:0] t, input logic [127:0] k);
        int n;
        @(posedge clk); #1;
        if (i == 0) begin t0 = t; k0 = k; ver0 = ver; v0 = 1'b1; end
        else        begin t1 = t; k1 = k; ver1 = ver; v1 = 1'b1; end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[i] && n < 400);
        if (n >= 400) check(1'b0, "accept_timeout", 64'(i), 64'h0);
        @(posedge clk); #1;
        if (i == 0) v0 = 1'b0; else v1 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || rsp_valid || busy) && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (n >= 600) check(1'b0, "drain_timeout", 64'(sb.size()), 64'h0);
    endtask

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, highs;
        logic [63:0] held_txt;
        logic        held_id;
        reset = 1'b1; v0 = 0; v1 = 0; ver0 = 0; ver1 = 0;
        t0 = '0; t1 = '0; k0 = '0; k1 = '0;
        rdy_dir = 1'b1; rand_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check(!rsp_valid && !busy, "reset_valid_busy", {62'b0, rsp_valid, busy}, 64'h0);
        check(req_ready == 2'b00, "reset_ready", {62'b0, req_ready}, 64'h0);
        check(!core_start && !core_step && core_round == 5'd0, "reset_core", {57'b0, core_start, core_step, core_round}, 64'h0);
        check(rsp_text == 64'h0 && !rsp_id, "reset_rsp", rsp_text, 64'h0);

        send(0, 1'b0, 64'h0123456789abcdef, 128'h00112233445566778899_000000000000);
        drain();
        send(1, 1'b1, 64'h0123456789abcdef, 128'h00112233445566778899aabbccddeeff);
        drain();

        acc_ids.delete();
        fork
            begin send(0, 1'b0, r64(), {r64(), r64()}); send(0, 1'b1, r64(), {r64(), r64()}); end
            begin send(1, 1'b1, r64(), {r64(), r64()}); send(1, 1'b0, r64(), {r64(), r64()}); end
        join
        drain();
        check(acc_ids.size() == 4, "tie_job_count", 64'(acc_ids.size()), 64'h4);
        for (int i = 0; i < 4 && i < acc_ids.size(); i++)
            check(acc_ids[i] == i % 2, "tie_order", 64'(acc_ids[i]), 64'(i % 2));

        rdy_dir = 1'b0;
        send(0, 1'b1, r64(), {r64(), r64()});
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        held_txt = rsp_text;
        held_id  = rsp_id;
        fork
            send(1, 1'b0, r64(), {r64(), r64()});
            begin
                repeat (10) @(posedge clk);
                #1;
                check(rsp_valid && rsp_text == held_txt && rsp_id == held_id, "stall_hold", rsp_text, held_txt);
                rdy_dir = 1'b1;
            end
        join
        drain();

        send(0, 1'b0, r64(), {r64(), r64()});
        n = 0;
        do begin @(negedge clk); n++; end while (!(core_step && core_round == 5'd12) && n < 100);
        reset = 1'b1;
        @(negedge clk);
        check(!busy && !core_step && !core_start && !rsp_valid, "reset_midrun", {60'b0, busy, core_step, core_start, rsp_valid}, 64'h0);
        @(posedge clk); #1 reset = 1'b0;
        highs = 0;
        repeat (40) begin @(negedge clk); if (rsp_valid) highs++; end
        check(highs == 0, "dropped_no_rsp", 64'(highs), 64'h0);
        send(1, 1'b1, r64(), {r64(), r64()});
        drain();

        acc_cyc.delete();
        send(0, 1'b0, r64(), {r64(), r64()});
        send(0, 1'b1, r64(), {r64(), r64()});
        drain();
        check(acc_cyc.size() == 2 && acc_cyc[1] - acc_cyc[0] == 29, "b2b_spacing",
              64'(acc_cyc.size() == 2 ? acc_cyc[1] - acc_cyc[0] : -1), 64'd29);

        rand_mode = 1'b1;
        for (int j = 0; j < 16; j++) begin
            fork
                if ($urandom_range(0, 3) != 0) send(0, 1'($urandom), r64(), {r64(), r64()});
                if ($urandom_range(0, 3) != 0) send(1, 1'($urandom), r64(), {r64(), r64()});
            join
        end
        rand_mode = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", t_run, t_fail);
        $finish;
    end

endmodule
`default_nettype wire
